// File: rtl/count_arbiter.sv
// Two-requester round-robin arbiter that grants one shared interval counter.
// A grant runs the counter from 0 to the winner's latched length, then pulses done for one cycle.
module count_arbiter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [CW-1:0] len0,
  input  logic [CW-1:0] len1,
  output logic [1:0]    gnt,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic [1:0]    done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_q;
  logic [1:0]    gnt_q;
  logic [1:0]    done_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] limit_q;
  logic          ptr_q;
  logic          owner_q;

  logic          owner_d;
  logic [CW-1:0] limit_d;
  logic          owner_req;

  // With both requesting the pointer decides; otherwise req[1] alone identifies the sole requester.
  always_comb begin
    owner_d   = (req == 2'b11) ? ptr_q : req[1];
    limit_d   = owner_d ? len1 : len0;
    owner_req = req[owner_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      count_q <= '0;
      limit_q <= '0;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 2'b00;
          if (req != 2'b00) begin
            state_q <= RUN;
            owner_q <= owner_d;
            gnt_q   <= owner_d ? 2'b10 : 2'b01;
            count_q <= '0;
            limit_q <= limit_d;
          end
        end
        RUN: begin
          // A dropped request wins over reaching the terminal count.
          if (!owner_req) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            count_q <= '0;
            ptr_q   <= ~owner_q;
          end else if (count_q == limit_q) begin
            state_q <= DONE;
            gnt_q   <= 2'b00;
            done_q  <= gnt_q;
            ptr_q   <= ~owner_q;
          end else begin
            count_q <= count_q + ONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 2'b00;
          count_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
          done_q  <= 2'b00;
          count_q <= '0;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign count = count_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_count_arbiter.sv
// Randomized and directed bench for count_arbiter, checked every cycle against an interval-level model.
module tb_count_arbiter;

  localparam int CW = 5;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req;
  logic [CW-1:0] len0;
  logic [CW-1:0] len1;
  logic [1:0]    gnt;
  logic [CW-1:0] count;
  logic          busy;
  logic [1:0]    done;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Model: who owns the counter (-1 none), how far the interval has run, and a one-cycle cooldown.
  int m_owner, m_elapsed, m_lim, m_rr, m_done_who;
  bit m_cool;

  count_arbiter #(.CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .len0  (len0),
    .len1  (len1),
    .gnt   (gnt),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_elapsed = 0; m_lim = 0; m_rr = 0; m_done_who = -1; m_cool = 0;
  endtask

  task automatic model_step();
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_rr = 1 - m_owner; m_owner = -1; m_elapsed = 0;
      end else if (m_elapsed == m_lim) begin
        m_rr = 1 - m_owner; m_done_who = m_owner; m_owner = -1; m_cool = 1;
      end else begin
        m_elapsed++;
      end
    end else if (m_cool) begin
      m_cool = 0; m_done_who = -1; m_elapsed = 0;
    end else if (req != 2'b00) begin
      m_owner   = (req == 2'b11) ? m_rr : ((req == 2'b01) ? 0 : 1);
      m_elapsed = 0;
      m_lim     = (m_owner == 0) ? int'(len0) : int'(len1);
    end
  endtask

  task automatic compare_all();
    int eg, ec, ed, eb;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    ec = (m_owner >= 0 || m_cool) ? m_elapsed : 0;
    ed = m_cool ? (1 << m_done_who) : 0;
    eb = (m_owner >= 0 || m_cool) ? 1 : 0;
    chk("gnt",   32'(gnt),   32'(eg));
    chk("count", 32'(count), 32'(ec));
    chk("done",  32'(done),  32'(ed));
    chk("busy",  32'(busy),  32'(eb));
    $display("t=%0t req=%b len0=%0d len1=%0d gnt=%b count=%0d done=%b busy=%b",
             $time, req, len0, len1, gnt, count, done, busy);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Reset asserted between edges; outputs must clear without any clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("rst_gnt",   32'(gnt),   32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    #1 rst_n = 1'b1;
  endtask

  task automatic tick_until_elapsed(input int target, input string tag);
    int n = 0;
    while (!(m_owner >= 0 && m_elapsed == target) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic go_idle();
    req = 2'b00;
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; len0 = '0; len1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por_gnt",   32'(gnt),   32'd0);
    chk("por_count", 32'(count), 32'd0);
    chk("por_busy",  32'(busy),  32'd0);
    chk("por_done",  32'(done),  32'd0);
    rst_n = 1'b1;

    // Single requester, len 3.
    req = 2'b01; len0 = 5'd3;
    repeat (6) tick();
    go_idle();

    // Both requesting from a fresh reset: requester 0 first, then alternation.
    async_reset();
    req = 2'b11; len0 = 5'd2; len1 = 5'd1;
    repeat (16) tick();
    go_idle();

    // Requester 1 with zero length, then maximum length (no wrap).
    req = 2'b10; len1 = 5'd0;
    repeat (3) tick();
    go_idle();
    req = 2'b10; len1 = 5'd31;
    repeat (36) tick();
    go_idle();

    // Abort at count 4; pointer should then favour requester 1.
    async_reset();
    req = 2'b01; len0 = 5'd10;
    tick_until_elapsed(4, "wait_abort");
    req = 2'b00;
    repeat (2) tick();
    req = 2'b11; len1 = 5'd2;
    repeat (3) tick();
    go_idle();

    // Async reset mid-run at count 5, then restart.
    req = 2'b01; len0 = 5'd10;
    tick_until_elapsed(5, "wait_rst");
    async_reset();
    repeat (4) tick();
    go_idle();

    // Length change during run must not move the terminal count.
    req = 2'b01; len0 = 5'd6;
    repeat (2) tick();
    len0 = 5'd2;
    repeat (9) tick();
    go_idle();

    // Randomized traffic with occasional async resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0:       len0 = 5'd0;
          1:       len1 = 5'd31;
          2:       len0 = 5'($urandom_range(0, 31));
          default: len1 = 5'($urandom_range(0, 7));
        endcase
      end
      tick();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/count_arbiter.md
COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 SHALL have parameter CW, default 5, counter width in bits; all scenarios below use CW=5.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  2  per-requester interval request, level, bit i = requester i.
REQ-005 SHALL have port len0  input  CW  requester 0 terminal count, sampled at grant.
REQ-006 SHALL have port len1  input  CW  requester 1 terminal count, sampled at grant.
REQ-007 SHALL have port gnt  output  2  registered grant, one-hot or zero.
REQ-008 SHALL have port count  output  CW  shared interval counter value, registered.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  output  2  one-cycle completion pulse, bit i = requester i.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; single shared counter and a 1-bit round-robin pointer ptr.
REQ-012 IDLE: if req != 0 at a clock edge, SHALL select winner and enter RUN at that edge; else stay IDLE.
REQ-013 Winner selection SHALL be: one requester active -> that one; both active -> requester ptr.
REQ-014 On IDLE->RUN edge SHALL set gnt[winner]=1, count=0, latch limit = len of winner.
REQ-015 RUN: each edge with count != limit and req[winner]=1 SHALL increment count by 1, gnt held.
REQ-016 RUN: edge with count == limit and req[winner]=1 SHALL enter DONE, clear gnt, hold count, pulse done[winner] for exactly the DONE cycle.
REQ-017 Grant duration SHALL be limit+1 cycles, count showing 0,1,...,limit; limit=0 gives one RUN cycle.
REQ-018 count SHALL never wrap within an interval; max limit 2^CW-1 reaches all-ones then DONE.
REQ-019 RUN: edge with req[winner]=0 (abort) SHALL enter IDLE directly, clear gnt, count=0, no done pulse; abort takes priority over terminal-count.
REQ-020 ptr SHALL be set to the non-winner on leaving RUN (completion or abort).
REQ-021 DONE: next edge SHALL unconditionally enter IDLE with count=0; requests in DONE ignored until IDLE (one idle turnaround cycle minimum).
REQ-022 len0/len1 changes after grant SHALL NOT affect the active interval.
REQ-023 Requests from the non-granted requester during RUN SHALL be ignored, no queueing beyond its held req level.
REQ-024 gnt SHALL never be 2'b11; done SHALL never be nonzero outside DONE; busy SHALL be combinationally state != IDLE.

Reset
REQ-025 rst_n low SHALL immediately clear state=IDLE, gnt=0, count=0, done=0, busy=0, limit=0, ptr=0 (requester 0 favoured), independent of clk.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort without done pulse; after rst_n deasserts first edge behaves as IDLE.

Verification
REQ-027 req=01, len0=3 -> gnt=01 for 4 cycles, count 0,1,2,3; done=01 one cycle next; busy 5 cycles; then IDLE count=0.
REQ-028 req=11 from reset, len0=2, len1=1, held -> req0 served first (count 0..2), done=01, idle cycle, then gnt=10 count 0..1, done=10, then gnt=01 again.
REQ-029 req=10, len1=0 -> gnt=10 one cycle count=0, done=10 next cycle; len1=31 -> count 0..31 no wrap, done after 32 grant cycles.
REQ-030 req=01 len0=10, drop req[0] when count=4 -> gnt=00 and count=0 next edge, done never asserted, ptr=1.
REQ-031 rst_n pulsed low mid-RUN at count=5 -> outputs zero asynchronously; after release req=01 restarts count at 0.
REQ-032 len0 changed from 6 to 2 during RUN -> interval still ends at count=6.
